// File: rtl/text_overlay.sv
// Text-mode character store (32 columns x ROWS rows of 6-bit codes) with a cursor
// write port, a whole-screen clear engine and a 2-stage pixel fetch into the glyph ROM.
module text_overlay #(
   parameter int unsigned ROWS       = 30,
   parameter logic [5:0]  BLANK_CHAR = 6'd38
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [5:0] wr_char,
   input  logic       cur_set,
   input  logic [4:0] cur_x,
   input  logic [4:0] cur_y,
   input  logic       clear,
   output logic       busy,
   output logic [4:0] cursor_x,
   output logic [4:0] cursor_y,
   input  logic       pix_req,
   input  logic [7:0] pix_x,
   input  logic [7:0] pix_y,
   output logic [5:0] char,
   output logic [2:0] row,
   input  logic [7:0] pixels,
   output logic       pix_valid,
   output logic       pix_on
);

   localparam logic [9:0] LAST_ADDR = 10'(ROWS * 32 - 1);
   localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
   localparam logic [8:0] Y_LIMIT   = 9'(ROWS * 8);

   typedef enum logic {
      S_IDLE,
      S_CLEAR
   } state_t;

   state_t     state, state_n;
   logic [9:0] clr_addr, clr_addr_n;
   logic [4:0] cx_n, cy_n;
   logic       we;
   logic [9:0] waddr;
   logic [5:0] wdata;

   logic [5:0] mem [0:1023];

   logic [2:0] col_q;
   logic       inr_q;
   logic       req_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_CLEAR;
         clr_addr <= '0;
         cursor_x <= '0;
         cursor_y <= '0;
      end else begin
         state    <= state_n;
         clr_addr <= clr_addr_n;
         cursor_x <= cx_n;
         cursor_y <= cy_n;
      end
   end

   always_comb begin
      state_n    = state;
      clr_addr_n = clr_addr;
      cx_n       = cursor_x;
      cy_n       = cursor_y;
      we         = 1'b0;
      waddr      = clr_addr;
      wdata      = BLANK_CHAR;
      busy       = (state == S_CLEAR);
      wr_ready   = (state == S_IDLE);
      case (state)
         S_CLEAR: begin
            we = 1'b1;
            if (clr_addr == LAST_ADDR) begin
               state_n    = S_IDLE;
               clr_addr_n = '0;
               cx_n       = '0;
               cy_n       = '0;
            end else begin
               clr_addr_n = clr_addr + 10'd1;
            end
         end
         S_IDLE: begin
            // clear beats cur_set beats write; lower-priority requests in the same cycle are dropped
            if (clear) begin
               state_n    = S_CLEAR;
               clr_addr_n = '0;
            end else if (cur_set) begin
               cx_n = cur_x;
               cy_n = (cur_y > LAST_ROW) ? LAST_ROW : cur_y;
            end else if (wr_valid) begin
               we    = 1'b1;
               waddr = {cursor_y, cursor_x};
               wdata = wr_char;
               if (cursor_x == 5'd31) begin
                  cx_n = '0;
                  cy_n = (cursor_y == LAST_ROW) ? 5'd0 : cursor_y + 5'd1;
               end else begin
                  cx_n = cursor_x + 5'd1;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (we && !reset) mem[waddr] <= wdata;
   end

   // Read sees the pre-write contents on a same-address collision (NBA ordering).
   always_ff @(posedge clk) begin
      if (reset) char <= BLANK_CHAR;
      else       char <= mem[{pix_y[7:3], pix_x[7:3]}];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row       <= '0;
         col_q     <= '0;
         inr_q     <= 1'b0;
         req_q     <= 1'b0;
         pix_valid <= 1'b0;
         pix_on    <= 1'b0;
      end else begin
         row       <= pix_y[2:0];
         col_q     <= pix_x[2:0];
         inr_q     <= ({1'b0, pix_y} < Y_LIMIT);
         req_q     <= pix_req;
         pix_valid <= req_q;
         pix_on    <= req_q & inr_q & pixels[~col_q];
      end
   end

endmodule

// File: tb/tb_text_overlay.sv
// Randomised scoreboard bench for text_overlay: a cell-array model predicts pixels,
// cursor and busy; a negedge monitor pops expected pixel entries as the DUT presents them.
module tb_text_overlay;

   localparam int ROWS  = 30;
   localparam int NCELL = ROWS * 32;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_valid = 1'b0;
   logic       cur_set = 1'b0;
   logic       clear = 1'b0;
   logic       pix_req = 1'b0;
   logic [5:0] wr_char = '0;
   logic [4:0] cur_x = '0;
   logic [4:0] cur_y = '0;
   logic [7:0] pix_x = '0;
   logic [7:0] pix_y = '0;
   logic       wr_ready, busy, pix_valid, pix_on;
   logic [4:0] cursor_x, cursor_y;
   logic [5:0] char;
   logic [2:0] row;
   logic [7:0] pixels;

   always #5 clk = ~clk;

   text_overlay #(.ROWS(ROWS), .BLANK_CHAR(6'd38)) dut (
      .clk(clk), .reset(reset),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_char(wr_char),
      .cur_set(cur_set), .cur_x(cur_x), .cur_y(cur_y),
      .clear(clear), .busy(busy),
      .cursor_x(cursor_x), .cursor_y(cursor_y),
      .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
      .char(char), .row(row), .pixels(pixels),
      .pix_valid(pix_valid), .pix_on(pix_on)
   );

   // Glyph ROM stand-in: blank space, a real 'A' and '0', hashed patterns elsewhere.
   function automatic logic [7:0] glyph(input logic [5:0] c, input logic [2:0] r);
      if (c == 6'd38) return 8'h00;
      if (c == 6'd10) begin
         case (r)
            3'd0: return 8'h38; 3'd1: return 8'h6C; 3'd2: return 8'hC6; 3'd3: return 8'hC6;
            3'd4: return 8'hFE; 3'd5: return 8'hC6; 3'd6: return 8'hC6; default: return 8'h00;
         endcase
      end
      if (c == 6'd0) begin
         case (r)
            3'd0: return 8'h7C; 3'd1: return 8'hC6; 3'd2: return 8'hCE; 3'd3: return 8'hD6;
            3'd4: return 8'hE6; 3'd5: return 8'hC6; 3'd6: return 8'h7C; default: return 8'h00;
         endcase
      end
      return 8'((int'(c) * 29) ^ (int'(r) * 83) ^ 'h5A);
   endfunction

   assign pixels = glyph(char, row);

   typedef struct {
      int due;
      bit v;
      bit on;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int   m_mem[NCELL];
   int   m_cx, m_cy, clr_left, clr_pos;
   int   cyc = 0;
   bit   mon_en = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Model of one clock edge given the inputs currently applied.
   task automatic model_edge();
      exp_t e;
      int   x, y, ch, p;
      logic [7:0] g;
      cyc++;
      if (reset) begin
         q.delete();
         q.push_back('{cyc, 1'b0, 1'b0});
         q.push_back('{cyc + 1, 1'b0, 1'b0});
         clr_left = NCELL;
         clr_pos  = 0;
         m_cx     = 0;
         m_cy     = 0;
         mon_en   = 1;
         return;
      end
      x = int'(pix_x);
      y = int'(pix_y);
      e.due = cyc + 1;
      e.v   = pix_req;
      e.on  = 1'b0;
      if (pix_req && y < ROWS * 8) begin
         ch   = m_mem[(y / 8) * 32 + x / 8];
         g    = glyph(6'(ch), 3'(y % 8));
         e.on = g[7 - x % 8];
      end
      q.push_back(e);
      if (clr_left > 0) begin
         m_mem[clr_pos] = 38;
         clr_pos++;
         clr_left--;
         if (clr_left == 0) begin
            m_cx = 0;
            m_cy = 0;
         end
      end else if (clear) begin
         clr_left = NCELL;
         clr_pos  = 0;
      end else if (cur_set) begin
         m_cx = int'(cur_x);
         m_cy = (int'(cur_y) > ROWS - 1) ? ROWS - 1 : int'(cur_y);
      end else if (wr_valid) begin
         p        = m_cy * 32 + m_cx;
         m_mem[p] = int'(wr_char);
         p        = (p + 1) % NCELL;
         m_cx     = p % 32;
         m_cy     = p / 32;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      if (mon_en) begin
         chk("busy", 32'(busy), 32'(clr_left > 0));
         chk("wr_ready", 32'(wr_ready), 32'(clr_left == 0));
         chk("cursor_x", 32'(cursor_x), 32'(m_cx));
         chk("cursor_y", 32'(cursor_y), 32'(m_cy));
      end
   endtask

   task automatic idle_inputs();
      wr_valid = 1'b0;
      cur_set  = 1'b0;
      clear    = 1'b0;
      pix_req  = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      idle_inputs();
      while (busy !== 1'b0 && n < limit) begin
         step();
         n++;
      end
      chk("wait_idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic read_px(input int x, input int y);
      pix_req = 1'b1;
      pix_x   = 8'(x);
      pix_y   = 8'(y);
      step();
      pix_req = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (q.size() > 0 && q[0].due == cyc) begin
            me = q.pop_front();
            chk("pix_valid", 32'(pix_valid), 32'(me.v));
            chk("pix_on", 32'(pix_on), 32'(me.on));
         end else begin
            chk("pix_valid_unexpected", 32'(pix_valid), 32'd0);
         end
      end
   end

   initial begin
      // Power-up clear
      reset = 1'b1;
      step();
      chk("char_reset", 32'(char), 32'd38);
      chk("row_reset", 32'(row), 32'd0);
      chk("pix_on_reset", 32'(pix_on), 32'd0);
      reset = 1'b0;
      wait_idle(2000);

      // Screen scan after clear: all blank
      for (int y = 0; y < 256; y += 3)
         for (int x = 0; x < 256; x++) read_px(x, y);
      step(); step();

      // 'A' at (3,2), glyph row 4
      cur_set = 1'b1; cur_x = 5'd3; cur_y = 5'd2;
      step();
      cur_set = 1'b0; wr_valid = 1'b1; wr_char = 6'd10;
      step();
      wr_valid = 1'b0;
      for (int x = 24; x < 32; x++) read_px(x, 20);
      step(); step();

      // Wrap from the last cell and cursor clamp
      cur_set = 1'b1; cur_x = 5'd31; cur_y = 5'd29;
      step();
      cur_set = 1'b0; wr_valid = 1'b1; wr_char = 6'd1;
      step();
      wr_char = 6'd2;
      step();
      wr_valid = 1'b0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            read_px(248 + c, 232 + r);
            read_px(c, r);
         end
      cur_set = 1'b1; cur_x = 5'd5; cur_y = 5'd31;
      step();
      cur_set = 1'b0;

      // Back-to-back requests with one bubble, including off-screen rows
      for (int i = 0; i < 256; i++) begin
         pix_req = (i != 100);
         pix_x   = 8'($urandom);
         pix_y   = (i < 16) ? 8'(240 + i) : 8'($urandom);
         step();
      end
      pix_req = 1'b0;
      step(); step();

      // clear + cur_set + write together, noise during clear, reset mid-clear
      clear = 1'b1; cur_set = 1'b1; wr_valid = 1'b1;
      cur_x = 5'd7; cur_y = 5'd3; wr_char = 6'd5;
      step();
      for (int i = 1; i < 500; i++) begin
         clear    = ($urandom_range(0, 15) == 0);
         cur_set  = ($urandom_range(0, 7) == 0);
         wr_valid = $urandom_range(0, 1);
         wr_char  = 6'($urandom);
         cur_x    = 5'($urandom);
         cur_y    = 5'($urandom);
         pix_req  = $urandom_range(0, 1);
         pix_x    = 8'($urandom);
         pix_y    = 8'($urandom);
         step();
      end
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
      wait_idle(2000);

      // Same-address write/read collision
      cur_set = 1'b1; cur_x = 5'd0; cur_y = 5'd0;
      step();
      cur_set = 1'b0; wr_valid = 1'b1; wr_char = 6'd10;
      step();
      wr_valid = 1'b0; cur_set = 1'b1;
      step();
      cur_set = 1'b0; wr_valid = 1'b1; wr_char = 6'd0;
      read_px(1, 0);
      wr_valid = 1'b0;
      for (int x = 0; x < 8; x++) read_px(x, 0);

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         int r;
         r        = $urandom_range(0, 9);
         cur_set  = (r == 0);
         wr_valid = (r >= 1 && r <= 4);
         cur_x    = 5'($urandom);
         cur_y    = 5'($urandom);
         wr_char  = 6'($urandom);
         pix_req  = $urandom_range(0, 1);
         pix_x    = 8'($urandom);
         pix_y    = 8'($urandom);
         step();
      end
      idle_inputs();
      for (int i = 0; i < 4 && q.size() > 2; i++) step();
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
